div_unit_ctrl: RTL and testbench

//  Multi-cycle sequencer and datapath for LoongArch div.w/mod.w/div.wu/mod.wu.

---
 rtl/div_unit_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_div_unit_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_ctrl.sv
// -----------------------------------------------------------------------------
// div_unit_ctrl
// Multi-cycle divider for LoongArch div.w / mod.w / div.wu / mod.wu.
// Lives beside the single-cycle ALU in EX. Operands arrive through a
// valid/ready handshake. The result leaves through a second valid/ready
// handshake. Division is radix-2 restoring and retires one quotient bit per
// cycle. Signed operations divide magnitudes and fix up the signs afterwards.
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-high
//   div_valid   request valid
//   div_ready   request accepted on div_valid & div_ready (high only when idle)
//   div_op      one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu
//   div_src1    dividend (rj)
//   div_src2    divisor  (rk)
//   div_cancel  pipeline flush; kills any operation in flight
//   out_valid   result valid
//   out_ready   consumer takes the result on out_valid & out_ready
//   div_result  quotient (div*) or remainder (mod*)
//   busy        high whenever the unit is not idle
// -----------------------------------------------------------------------------
module div_unit_ctrl #(
    parameter int               WIDTH  = 32,
    parameter int               CNT_W  = 6,
    parameter logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic [3:0]       div_op,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] div_result,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Operand / datapath registers (no reset: qualified by the state machine)
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic             sgn_q;
    logic             mod_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;

    // Two's complement negation, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Sign handling: selects the negated value when the flag is set.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? negate(v) : v;
    endfunction

    // Decode of the request. An op that is not one-hot runs as an unsigned
    // divide; its result is meaningless but the sequence still completes.
    logic op_legal;
    logic op_sgn;
    logic op_mod;

    assign op_legal = $onehot(div_op);
    assign op_sgn   = op_legal & (div_op[0] | div_op[1]);
    assign op_mod   = op_legal & (div_op[1] | div_op[3]);

    // Sign pre-fixup: magnitudes of signed operands. |-2^(W-1)| wraps to
    // 2^(W-1), which is exactly the right unsigned magnitude.
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    assign s1_neg = sgn_q & src1_q[WIDTH-1];
    assign s2_neg = sgn_q & src2_q[WIDTH-1];
    assign mag1   = apply_sign(src1_q, s1_neg);
    assign mag2   = apply_sign(src2_q, s2_neg);

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits
    // because the divisor may exceed 2^(W-1). When it is >= divisor the
    // difference is below the divisor, so WIDTH bits hold it exactly.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, dvs_q});
    assign diff   = rem_sh[WIDTH-1:0] - dvs_q;

    // ---- datapath registers ----
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (div_valid && !div_cancel) begin
                    src1_q <= div_src1;
                    src2_q <= div_src2;
                    sgn_q  <= op_sgn;
                    mod_q  <= op_mod;
                end
            end
            S_PREP: begin
                rem_q   <= '0;
                quo_q   <= mag1;
                dvs_q   <= mag2;
                q_neg_q <= s1_neg ^ s2_neg;
                r_neg_q <= s1_neg;
            end
            S_CALC: begin
                rem_q <= ge ? diff : rem_sh[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], ge};
            end
            default: begin
            end
        endcase
    end

    // ---- control state machine with registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            div_ready  <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            div_result <= '0;
            cnt        <= '0;
        end else if (div_cancel && state != S_IDLE) begin
            // Flush: drop whatever is in flight, including a pending result.
            state     <= S_IDLE;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_valid && !div_cancel) begin
                        state     <= S_PREP;
                        div_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_PREP: begin
                    if (src2_q == '0) begin
                        // Divide by zero bypasses the iterations entirely.
                        div_result <= mod_q ? src1_q : ZERO_Q;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    div_result <= mod_q ? apply_sign(rem_q, r_neg_q)
                                        : apply_sign(quo_q, q_neg_q);
                    out_valid  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        div_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    div_ready <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_unit_ctrl
// Self-checking bench for div_unit_ctrl: a directed vector table, hand-written
// corner sequences (cancel, back-pressure, reset mid-operation) and random
// operations compared against an arithmetic reference model.
// Latency is counted in edges with the accepting edge counted as edge 1.
// -----------------------------------------------------------------------------
module tb_div_unit_ctrl;

    localparam logic [3:0] OP_DIV_W  = 4'b0001;
    localparam logic [3:0] OP_MOD_W  = 4'b0010;
    localparam logic [3:0] OP_DIV_WU = 4'b0100;
    localparam logic [3:0] OP_MOD_WU = 4'b1000;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic [3:0]  div_op;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] div_result;
    logic        busy;

    int total;
    int passed;

    div_unit_ctrl #(.WIDTH(32), .CNT_W(6), .ZERO_Q(32'hFFFF_FFFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_cancel (div_cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .div_result (div_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Reference model straight from the arithmetic definition.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        bit          sgn;
        bit          md;
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        sgn = op[0] | op[1];
        md  = op[1] | op[3];
        if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return md ? r : q;
    endfunction

    // Issue one request (starting at a negedge), wait for the result, hold
    // out_ready low for 'hold' cycles checking stability, then consume it.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output logic [31:0] res, output int lat);
        chk({name, "_ready_before"}, 32'(div_ready), 32'd1);
        div_valid = 1'b1;
        div_op    = op;
        div_src1  = a;
        div_src2  = b;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = div_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_result"}, div_result, res);
            chk({name, "_hold_ready"}, 32'(div_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
        chk({name, "_ready_after"}, 32'(div_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          seen;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        total      = 0;
        passed     = 0;
        reset      = 1'b1;
        div_valid  = 1'b0;
        div_op     = OP_DIV_W;
        div_src1   = '0;
        div_src2   = '0;
        div_cancel = 1'b0;
        out_ready  = 1'b0;

        vecs[0]  = '{OP_DIV_W,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 35};
        vecs[1]  = '{OP_MOD_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35};
        vecs[2]  = '{OP_MOD_WU, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 35};
        vecs[3]  = '{OP_DIV_WU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 35};
        vecs[4]  = '{OP_DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35};
        vecs[5]  = '{OP_MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 35};
        vecs[6]  = '{OP_DIV_W,  32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        vecs[7]  = '{OP_MOD_W,  32'd5,          32'd0,         32'h0000_0005, 2};
        vecs[8]  = '{OP_DIV_WU, 32'd100,        32'd7,         32'h0000_000E, 35};
        vecs[9]  = '{OP_MOD_W,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 35};
        vecs[10] = '{OP_DIV_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35};
        vecs[11] = '{OP_DIV_WU, 32'd5,          32'hFFFF_FFFF, 32'h0000_0000, 35};
        vecs[12] = '{OP_MOD_WU, 32'd12345,      32'd0,         32'd12345,     2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_div_ready", 32'(div_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_div_result", div_result, 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Cancel same cycle as request in IDLE: not accepted
        div_valid  = 1'b1;
        div_op     = OP_DIV_W;
        div_src1   = 32'd9;
        div_src2   = 32'd3;
        div_cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_valid  = 1'b0;
        div_cancel = 1'b0;
        chk("idle_cancel_busy", 32'(busy), 32'd0);
        chk("idle_cancel_ready", 32'(div_ready), 32'd1);

        // Cancel at CALC iteration 10
        div_valid = 1'b1;
        div_op    = OP_DIV_W;
        div_src1  = 32'd1000;
        div_src2  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("calc_busy_before_cancel", 32'(busy), 32'd1);
        div_cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_cancel = 1'b0;
        chk("calc_cancel_busy", 32'(busy), 32'd0);
        chk("calc_cancel_ready", 32'(div_ready), 32'd1);
        chk("calc_cancel_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("calc_cancel_no_valid", 32'(seen), 32'd0);
        run_op("after_cancel", OP_DIV_WU, 32'd100, 32'd7, 0, res, lat);
        chk("after_cancel_result", res, 32'h0000_000E);
        chk("after_cancel_latency", 32'(lat), 32'd35);

        // Back-pressure: out_ready low for 5 cycles in DONE
        run_op("backpressure", OP_DIV_W, 32'd7, 32'hFFFF_FFFE, 5, res, lat);
        chk("backpressure_result", res, 32'hFFFF_FFFD);
        chk("backpressure_latency", 32'(lat), 32'd35);

        // Cancel in DONE with out_ready high: cancel wins
        div_valid = 1'b1;
        div_op    = OP_MOD_WU;
        div_src1  = 32'd50;
        div_src2  = 32'd0;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("done_cancel_reached", 32'(out_valid), 32'd1);
        out_ready  = 1'b1;
        div_cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready  = 1'b0;
        div_cancel = 1'b0;
        chk("done_cancel_valid", 32'(out_valid), 32'd0);
        chk("done_cancel_ready", 32'(div_ready), 32'd1);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            op = 4'b0001 << $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'(int'($urandom_range(0, 20)) - 10);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'(int'($urandom_range(0, 30)) - 15);
                3:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 1), res, lat);
            chk($sformatf("rnd%0d_result op=%b a=%08h b=%08h", n, op, a, b), res, model(op, a, b));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), (b == 32'd0) ? 32'd2 : 32'd35);
        end

        // Reset asserted mid-CALC
        div_valid = 1'b1;
        div_op    = OP_DIV_WU;
        div_src1  = 32'hDEAD_BEEF;
        div_src2  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midcalc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_div_ready", 32'(div_ready), 32'd1);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_div_result", div_result, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        run_op("post_reset", OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 0, res, lat);
        chk("post_reset_result", res, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
